fifo_rd_ctrl: RTL and testbench

Read-side controller for the team's synchronous FIFO (syc_fifo). On a start command it drains a programmed number of words from the FIFO read port and presents them downstream on a valid/ready stream. It hides the FIFO's one-cycle read latency with a 2-entry skid buffer, so throughput is one word per cycle under no backpressure. It sits between syc_fifo and any consumer, such as a serializer or DMA sink.

---
 rtl/fifo_rd_ctrl.sv | 112 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - burst read controller for syc_fifo
// Drains a programmed word count through a 2-entry skid buffer onto a valid/ready stream.
module fifo_rd_ctrl #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_re,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_out
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [WIDTH-1:0] skid0;
  logic [WIDTH-1:0] skid1;
  logic [1:0]       occ;
  logic [1:0]       occ_next;
  logic [1:0]       wr_slot;
  logic             inflight;
  logic             pop;
  logic             start_ok;
  logic             credit_ok;
  logic [2:0]       avail;

  assign m_valid   = (occ != 2'd0);
  assign m_data    = skid0;
  assign pop       = m_valid && m_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Free slots once this cycle's pop and the outstanding read are accounted for.
  assign avail     = 3'd2 + {2'b00, pop} - {1'b0, occ} - {2'b00, inflight};
  assign credit_ok = (avail != 3'd0);
  assign occ_next  = occ + {1'b0, inflight} - {1'b0, pop};
  assign wr_slot   = occ - {1'b0, pop};

  always_comb begin
    state_next = state;
    fifo_re    = 1'b0;
    start_ok   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_next = (burst_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        fifo_re = !fifo_empty && (issued < len_q) && credit_ok;
        if (fifo_re && ((issued + LEN_ONE) == len_q)) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        // Leave as soon as the buffer will be empty, so done follows the last handshake directly.
        if (occ_next == 2'd0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      issued    <= '0;
      words_out <= '0;
      occ       <= 2'd0;
      inflight  <= 1'b0;
      skid0     <= '0;
      skid1     <= '0;
    end else begin
      state    <= state_next;
      inflight <= fifo_re;
      occ      <= occ_next;
      if (start_ok) begin
        len_q     <= burst_len;
        issued    <= '0;
        words_out <= '0;
      end else begin
        if (fifo_re) issued <= issued + LEN_ONE;
        if (pop) words_out <= words_out + LEN_ONE;
      end
      if (pop) skid0 <= skid1;
      // The captured word lands behind whatever survives this cycle's pop.
      if (inflight) begin
        if (wr_slot == 2'd0) skid0 <= fifo_dout;
        else skid1 <= fifo_dout;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - scoreboard bench for fifo_rd_ctrl with a behavioural syc_fifo model
module tb_fifo_rd_ctrl;
  localparam int WIDTH = 8;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] burst_len = '0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             fifo_re;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready = 1'b0;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] words_out;

  fifo_rd_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_re(fifo_re),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .done(done), .words_out(words_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] wr_pend[$];
  logic [WIDTH-1:0] exp_q[$];
  int  len_exp_q[$];
  int  burst_hs = 0;
  int  hs_total = 0;
  bit  rand_ready = 1'b0;
  bit  prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // syc_fifo model: one-cycle read latency, writes land at the same edge as reads.
  always @(posedge clk) begin : fifo_model
    logic [WIDTH-1:0] rd;
    if (fifo_re && fifo_q.size() > 0) begin
      rd = fifo_q.pop_front();
      fifo_dout <= rd;
    end
    while (wr_pend.size() > 0) fifo_q.push_back(wr_pend.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(posedge clk) begin
    #2;
    if (rand_ready) m_ready = ($urandom_range(0, 1) == 1);
  end

  always @(negedge clk) begin : monitor
    int l;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (fifo_re) check("re_while_empty", int'(fifo_empty), 0);
      if (prev_stall) begin
        check("hold_valid", int'(m_valid), 1);
        check("hold_data", int'(m_data), int'(prev_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_word: got %0d, required no word", m_data);
        end else begin
          check("m_data", int'(m_data), int'(exp_q.pop_front()));
        end
        burst_hs++;
        hs_total++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (done) begin
        if (len_exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_done: got done=1, required no burst completion");
        end else begin
          l = len_exp_q.pop_front();
          check("words_out", int'(words_out), l);
          check("burst_handshakes", burst_hs, l);
        end
        burst_hs = 0;
      end
    end
  end

  task automatic write_words(input int n, input bit seq, input int base);
    for (int i = 0; i < n; i++) begin
      logic [WIDTH-1:0] d;
      d = seq ? WIDTH'(base + i) : WIDTH'($urandom);
      wr_pend.push_back(d);
      exp_q.push_back(d);
    end
    tick();
  endtask

  task automatic do_start(input int len, input bit accept);
    start = 1'b1;
    burst_len = LEN_W'(len);
    if (accept) len_exp_q.push_back(len);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, "_done_seen"}, int'(seen), 1);
    tick();
  endtask

  // Full-rate burst with m_ready held high; the FIFO holds at least len words.
  task automatic measure_burst(input string name, input int len);
    int re_cnt, first_re, last_re, last_hs, done_cyc, gaps, hs;
    bit seen_valid;
    re_cnt = 0; first_re = -1; last_re = -1; last_hs = -100; done_cyc = -1;
    gaps = 0; hs = 0; seen_valid = 1'b0;
    m_ready = 1'b1;
    do_start(len, 1'b1);
    for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (fifo_re) begin
        re_cnt++;
        if (first_re < 0) first_re = cyc;
        last_re = cyc;
      end
      if (m_valid) begin
        seen_valid = 1'b1;
        hs++;
        last_hs = cyc;
      end else if (seen_valid && hs < len) begin
        gaps++;
      end
      if (done) done_cyc = cyc;
    end
    check({name, "_first_re_cycle"}, first_re, 1);
    check({name, "_re_count"}, re_cnt, len);
    check({name, "_re_span"}, last_re - first_re, len - 1);
    check({name, "_valid_gaps"}, gaps, 0);
    check({name, "_done_after_last_hs"}, done_cyc - last_hs, 1);
    check({name, "_words_out"}, int'(words_out), len);
    tick();
    check({name, "_fifo_empty"}, int'(fifo_empty), 1);
  endtask

  initial begin
    int re_cnt, hs0, n, len;
    #1 rst = 1'b1;
    #1;
    check("rst_fifo_re", int'(fifo_re), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_words_out", int'(words_out), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Full 16-word burst at full rate.
    write_words(16, 1'b1, 0);
    measure_burst("s1", 16);

    // Backpressure at burst start.
    write_words(16, 1'b1, 0);
    m_ready = 1'b0;
    do_start(4, 1'b1);
    re_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fifo_re) re_cnt++;
    end
    check("s2_stall_re_at_most_2", int'(re_cnt <= 2), 1);
    check("s2_stall_valid", int'(m_valid), 1);
    check("s2_stall_data", int'(m_data), 0);
    tick();
    m_ready = 1'b1;
    wait_done("s2", 40);
    check("s2_fifo_left", fifo_q.size(), 12);

    rand_ready = 1'b1;
    do_start(12, 1'b1);
    wait_done("drain", 120);
    rand_ready = 1'b0;
    tick();
    m_ready = 1'b1;

    // Underrun: burst longer than the FIFO contents stalls in RUN.
    write_words(3, 1'b0, 0);
    hs0 = hs_total;
    do_start(5, 1'b1);
    repeat (12) @(negedge clk);
    check("s3_partial_words", hs_total - hs0, 3);
    check("s3_busy", int'(busy), 1);
    check("s3_fifo_re", int'(fifo_re), 0);
    tick();
    write_words(2, 1'b0, 0);
    wait_done("s3", 30);

    // Zero-length burst.
    write_words(1, 1'b0, 0);
    do_start(0, 1'b1);
    @(negedge clk);
    check("s4_done_cycle", int'(done), 1);
    check("s4_fifo_re_a", int'(fifo_re), 0);
    @(negedge clk);
    check("s4_done_single", int'(done), 0);
    check("s4_fifo_re_b", int'(fifo_re), 0);
    tick();
    check("s4_fifo_untouched", fifo_q.size(), 1);

    // Start while busy is ignored.
    write_words(7, 1'b0, 0);
    rand_ready = 1'b1;
    do_start(6, 1'b1);
    tick();
    tick();
    start = 1'b1;
    burst_len = LEN_W'(2);
    tick();
    start = 1'b0;
    wait_done("s5", 80);
    rand_ready = 1'b0;
    tick();
    check("s5_fifo_left", fifo_q.size(), 2);

    // Asynchronous reset with a full skid buffer.
    write_words(6, 1'b0, 0);
    m_ready = 1'b0;
    do_start(8, 1'b1);
    repeat (5) tick();
    check("s6_pre_valid", int'(m_valid), 1);
    #1 rst = 1'b1;
    #1;
    check("s6_rst_fifo_re", int'(fifo_re), 0);
    check("s6_rst_m_valid", int'(m_valid), 0);
    check("s6_rst_m_data", int'(m_data), 0);
    check("s6_rst_busy", int'(busy), 0);
    check("s6_rst_done", int'(done), 0);
    check("s6_rst_words_out", int'(words_out), 0);
    exp_q = fifo_q;
    len_exp_q.delete();
    burst_hs = 0;
    tick();
    rst = 1'b0;
    tick();
    check("s6_fifo_after_rst", fifo_q.size(), 6);
    measure_burst("s6", fifo_q.size());

    // Randomized bursts under random backpressure.
    for (int it = 0; it < 15; it++) begin
      n = $urandom_range(0, 16 - fifo_q.size());
      if (n > 0) write_words(n, 1'b0, 0);
      len = $urandom_range(0, fifo_q.size());
      rand_ready = 1'b1;
      do_start(len, 1'b1);
      wait_done("rand", 200);
      rand_ready = 1'b0;
      tick();
      m_ready = 1'b1;
    end

    tick();
    check("end_scoreboard_left", exp_q.size(), fifo_q.size());
    check("end_bursts_left", len_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule
